// File: rtl/sync_tx_scheduler.sv
// rtl/sync_tx_scheduler.sv - round-robin scheduler driving a qualified data word to a clock-domain crossing
module sync_tx_scheduler #(
  parameter int BUS_WIDTH = 8,
  parameter int NUM_REQ   = 4,
  parameter int ID_W      = 2
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*BUS_WIDTH-1:0] req_data,
  input  logic [3:0]                   cfg_hold,
  input  logic [3:0]                   cfg_gap,
  output logic [NUM_REQ-1:0]           gnt,
  output logic [BUS_WIDTH-1:0]         unsync_bus,
  output logic                         bus_enable,
  output logic [ID_W-1:0]              src_id,
  output logic                         busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [ID_W:0] NUM_REQ_W = (ID_W+1)'(NUM_REQ);

  state_t               state, state_n;
  logic [ID_W-1:0]      rr_ptr, rr_ptr_n;
  logic [3:0]           hold_cnt, hold_cnt_n;
  // gap_cnt is loaded with G at the grant edge and only counts inside GAP,
  // so it doubles as the latched gap length during HOLD.
  logic [3:0]           gap_cnt, gap_cnt_n;
  logic [NUM_REQ-1:0]   gnt_n;
  logic [BUS_WIDTH-1:0] bus_n;
  logic                 be_n;
  logic [ID_W-1:0]      id_n;

  logic [NUM_REQ-1:0]   req_rot;
  logic [ID_W-1:0]      offset;
  logic [ID_W-1:0]      winner;
  logic [ID_W-1:0]      winner_inc;
  logic [ID_W:0]        win_sum;
  logic [ID_W:0]        inc_sum;
  logic [BUS_WIDTH-1:0] win_word;
  logic [NUM_REQ-1:0]   win_onehot;

  // Winner search: rotate req so rr_ptr lands on bit 0, take the lowest set bit, map back.
  always_comb begin
    req_rot = NUM_REQ'({req, req} >> rr_ptr);
    offset  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) offset = k[ID_W-1:0];
    end
    win_sum = {1'b0, rr_ptr} + {1'b0, offset};
    if (win_sum >= NUM_REQ_W) win_sum = win_sum - NUM_REQ_W;
    winner  = win_sum[ID_W-1:0];
    inc_sum = {1'b0, winner} + (ID_W+1)'(1);
    if (inc_sum == NUM_REQ_W) inc_sum = '0;
    winner_inc = inc_sum[ID_W-1:0];
    win_word   = '0;
    win_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == i[ID_W-1:0]) begin
        win_word      = req_data[i*BUS_WIDTH +: BUS_WIDTH];
        win_onehot[i] = 1'b1;
      end
    end
  end

  // Next-state and next-output decode; gnt and bus_enable default low, data path holds.
  always_comb begin
    state_n    = state;
    rr_ptr_n   = rr_ptr;
    hold_cnt_n = hold_cnt;
    gap_cnt_n  = gap_cnt;
    gnt_n      = '0;
    be_n       = 1'b0;
    bus_n      = unsync_bus;
    id_n       = src_id;
    unique case (state)
      IDLE: begin
        if (|req) begin
          state_n    = HOLD;
          rr_ptr_n   = winner_inc;
          hold_cnt_n = (cfg_hold == 4'd0) ? 4'd1 : cfg_hold;
          gap_cnt_n  = cfg_gap;
          gnt_n      = win_onehot;
          be_n       = 1'b1;
          bus_n      = win_word;
          id_n       = winner;
        end
      end
      HOLD: begin
        if (hold_cnt > 4'd1) begin
          hold_cnt_n = hold_cnt - 4'd1;
          be_n       = 1'b1;
        end else begin
          hold_cnt_n = 4'd0;
          state_n    = (gap_cnt == 4'd0) ? IDLE : GAP;
        end
      end
      GAP: begin
        if (gap_cnt > 4'd1) begin
          gap_cnt_n = gap_cnt - 4'd1;
        end else begin
          gap_cnt_n = 4'd0;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Pointer, counters and registered crossing outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rr_ptr     <= '0;
      hold_cnt   <= '0;
      gap_cnt    <= '0;
      gnt        <= '0;
      bus_enable <= 1'b0;
      unsync_bus <= '0;
      src_id     <= '0;
    end else begin
      rr_ptr     <= rr_ptr_n;
      hold_cnt   <= hold_cnt_n;
      gap_cnt    <= gap_cnt_n;
      gnt        <= gnt_n;
      bus_enable <= be_n;
      unsync_bus <= bus_n;
      src_id     <= id_n;
    end
  end

  assign busy = (state != IDLE);

endmodule
